// File: rtl/priority_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// priority_arbiter_ctrl
//
// Grants one shared downstream resource to one of N requesters at a time.
// Arbitration is fixed-priority (highest set index wins) or round-robin
// (search downward from last_id-1, wrapping, so the last winner is lowest).
// A grant is held until its owner drops the request or MAX_HOLD cycles
// elapse. Every grant ends with a return to IDLE, which gives one all-zero
// turnaround cycle between consecutive owners.
//
// Handshake: req[i] is a level-sensitive "valid". grant[i] is the "ready"
// that answers it. A requester owns the resource for every cycle its grant
// bit is high. Dropping req[i] while granted releases the resource at the
// next edge. No grant is ever issued to a requester whose req was low in
// the arbitration cycle.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   req        in   N      request lines, bit i = requester i
//   rr_en      in   1      1 = round-robin, 0 = fixed priority (used in IDLE only)
//   grant      out  N      registered one-hot grant, zero when no owner
//   grant_id   out  IDW    binary index of the owner, zero when no owner
//   busy       out  1      high while a grant is active
//   timeout    out  1      one-cycle pulse when a grant is revoked by MAX_HOLD
//   dbg_state  out  1      current FSM state (0 = IDLE, 1 = GRANT)
// ---------------------------------------------------------------------------
module priority_arbiter_ctrl #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 15,
    localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           rr_en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           timeout,
    output logic           dbg_state
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] last_id_q, last_id_d;
    logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
    logic           timeout_q, timeout_d;

    logic [IDW-1:0] winner;
    logic           found;
    logic [IDW-1:0] rr_idx;

    // Winner selection. Fixed mode: the last set bit in ascending order is the
    // highest index. Round-robin: probe last_id-1, last_id-2, ... last_id
    // (mod N) and take the first requester seen.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = '0;
        if (!rr_en) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    winner = IDW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                rr_idx = IDW'((int'(last_id_q) + N - k) % N);
                if (!found && req[rr_idx]) begin
                    winner = rr_idx;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        id_d       = id_q;
        last_id_d  = last_id_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d    = {{(N-1){1'b0}}, 1'b1} << winner;
                    id_d       = winner;
                    last_id_d  = winner;
                    hold_cnt_d = CW'(1);
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // Release is checked first so it wins over a same-edge timeout.
                if (!req[id_q]) begin
                    grant_d    = '0;
                    id_d       = '0;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else if (hold_cnt_q == CW'(MAX_HOLD)) begin
                    grant_d    = '0;
                    id_d       = '0;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                    state_d    = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            id_q       <= '0;
            last_id_q  <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            id_q       <= id_d;
            last_id_q  <= last_id_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign grant_id  = id_q;
    assign busy      = (state_q == GRANT);
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_priority_arbiter_ctrl.sv
module tb_priority_arbiter_ctrl;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = 2;
    localparam int W        = N + IDW + 2;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic           rr_en = 1'b0;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout;
    logic           dbg_state;
    logic [W-1:0]   obs;

    always #5 clk = ~clk;

    priority_arbiter_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_en     (rr_en),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    assign obs = {grant, grant_id, busy, timeout};

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // owner = -1 means nobody holds the resource.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = 0;
    bit m_to    = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input logic rr, input int last);
        if (!rr) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = ((last - k) % N + N) % N;
                if (r[idx]) return idx;
            end
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] exp_vec();
        logic [N-1:0]   g;
        logic [IDW-1:0] id;
        g  = '0;
        id = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            id = IDW'(m_owner);
        end
        return {g, id, (m_owner >= 0), m_to};
    endfunction

    function automatic void model_edge(input logic r_rst, input logic [N-1:0] r, input logic rr);
        if (r_rst) begin
            m_owner = -1; m_cnt = 0; m_last = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (r != 0) begin
                m_owner = pick(r, rr, m_last);
                m_last  = m_owner;
                m_cnt   = 1;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1; m_to = 1'b0;
        end else if (m_cnt == MAX_HOLD) begin
            m_owner = -1; m_to = 1'b1;
        end else begin
            m_cnt++;
            m_to = 1'b0;
        end
    endfunction

    // ---------------- driver ----------------
    // Drive at the falling edge, advance the model at the rising edge,
    // and leave the caller 1 time unit after the edge to sample outputs.
    task automatic tick(input logic r_rst, input logic [N-1:0] r, input logic rr);
        @(negedge clk);
        rst   = r_rst;
        req   = r;
        rr_en = rr;
        @(posedge clk);
        model_edge(r_rst, r, rr);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            tick(1'b1, 4'b1111, 1'b0);
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("FAIL reset cycle %0d: got %b expected all zero", c, obs);
            end
        end
    endtask

    task automatic test_fixed_basic();
        tick(1'b1, 4'b0000, 1'b0);
        tick(1'b0, 4'b0110, 1'b0);
        checks++;
        if (grant !== 4'b0100 || grant_id !== 2'd2 || obs !== exp_vec()) begin
            failures++;
            $display("FAIL fixed_first: got grant=%b id=%0d expected grant=0100 id=2", grant, grant_id);
        end
        tick(1'b0, 4'b0010, 1'b0);
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL fixed_release: got %b expected all zero", obs);
        end
        tick(1'b0, 4'b0010, 1'b0);
        checks++;
        if (grant !== 4'b0010 || grant_id !== 2'd1 || obs !== exp_vec()) begin
            failures++;
            $display("FAIL fixed_second: got grant=%b id=%0d expected grant=0010 id=1", grant, grant_id);
        end
    endtask

    task automatic test_rr_rotation();
        int exp_ids[5] = '{3, 2, 1, 0, 3};
        tick(1'b1, 4'b0000, 1'b1);
        for (int s = 0; s < 5; s++) begin
            tick(1'b0, 4'b1111, 1'b1);
            checks++;
            if (grant_id !== IDW'(exp_ids[s]) || busy !== 1'b1 || obs !== exp_vec()) begin
                failures++;
                $display("FAIL rr_rotation step %0d: got id=%0d busy=%b expected id=%0d busy=1",
                         s, grant_id, busy, exp_ids[s]);
            end
            tick(1'b0, 4'b1111 & ~(4'b0001 << exp_ids[s]), 1'b1);
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("FAIL rr_dead_cycle step %0d: got %b expected all zero", s, obs);
            end
        end
    endtask

    task automatic test_timeout();
        tick(1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < MAX_HOLD; c++) begin
            tick(1'b0, 4'b1000, 1'b0);
            checks++;
            if (grant !== 4'b1000 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL timeout_hold cycle %0d: got grant=%b timeout=%b expected grant=1000 timeout=0",
                         c, grant, timeout);
            end
        end
        tick(1'b0, 4'b1000, 1'b0);
        checks++;
        if (grant !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: got grant=%b timeout=%b busy=%b expected 0000 1 0", grant, timeout, busy);
        end
        tick(1'b0, 4'b1000, 1'b0);
        checks++;
        if (grant !== 4'b1000 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_regrant: got grant=%b timeout=%b expected grant=1000 timeout=0", grant, timeout);
        end
    endtask

    task automatic test_rr_mask();
        tick(1'b1, 4'b0000, 1'b1);
        tick(1'b0, 4'b0100, 1'b1);
        tick(1'b0, 4'b0000, 1'b1);
        tick(1'b0, 4'b0101, 1'b1);
        checks++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL rr_mask: got grant=%b id=%0d expected grant=0001 id=0", grant, grant_id);
        end
        tick(1'b0, 4'b0000, 1'b1);
        tick(1'b0, 4'b0001, 1'b1);
        checks++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL rr_wrap_self: got grant=%b id=%0d expected grant=0001 id=0", grant, grant_id);
        end
    endtask

    task automatic test_reset_mid_grant();
        tick(1'b1, 4'b0000, 1'b0);
        tick(1'b0, 4'b0100, 1'b0);
        tick(1'b0, 4'b0100, 1'b0);
        checks++;
        if (grant !== 4'b0100) begin
            failures++;
            $display("FAIL reset_mid_setup: got grant=%b expected 0100", grant);
        end
        tick(1'b1, 4'b0100, 1'b0);
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear: got %b expected all zero", obs);
        end
        tick(1'b0, 4'b1111, 1'b1);
        checks++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            failures++;
            $display("FAIL reset_mid_first_rr: got grant=%b id=%0d expected grant=1000 id=3", grant, grant_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         rr;
        logic         rs;
        tick(1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            r  = N'($urandom_range(0, (1 << N) - 1));
            if (m_owner >= 0 && $urandom_range(0, 4) != 0) r[m_owner] = 1'b1;
            if ($urandom_range(0, 5) == 0) r = '0;
            rr = ($urandom_range(0, 1) == 1);
            rs = ($urandom_range(0, 150) == 0);
            tick(rs, r, rr);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL random cycle %0d: got %b expected %b (req=%b rr=%b rst=%b)",
                         c, obs, exp_vec(), r, rr, rs);
            end
            checks++;
            if ((grant & (grant - 1'b1)) !== '0 || (timeout && grant !== '0)) begin
                failures++;
                $display("FAIL random_invariant cycle %0d: got grant=%b timeout=%b expected onehot-or-zero, no overlap",
                         c, grant, timeout);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_fixed_basic();
        test_rr_rotation();
        test_timeout();
        test_rr_mask();
        test_reset_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
